hazard_control_unit: RTL and testbench

Pipeline hazard and control unit for the 5-stage RISC-V core, sitting at the execute end of the decode-to-execute pipeline register and driving its hold/bubble controls back towards fetch and decode. It does three things:
- Computes operand forwarding selects for the execute stage.
- Inserts load-use bubbles and flushes wrong-path instructions on a taken branch or jump.
- Freezes the whole pipeline while data memory is busy, and keeps saturating hazard statistics counters plus a sticky memory-timeout flag.

---
 rtl/hazard_pkg.sv | 46 ++++
 rtl/hazard_sat_counter.sv | 41 ++++
 rtl/hazard_control_unit.sv | 181 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : hazard_pkg                                                   |
// | Description : Shared types and constants for the pipeline hazard and      |
// |               control unit: forwarding select encoding, control FSM       |
// |               states, register-index width and the forwarding helper.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10
  } fwd_sel_e;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hcu_state_e;

  // Operand source for one execute-stage operand. The memory-stage result is
  // younger than the writeback result, so it takes precedence when both match.
  // x0 is hard-wired to zero and must never be forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_IDX_W-1:0] ex_rs,
    input logic [REG_IDX_W-1:0] mem_rd,
    input logic                 mem_we,
    input logic [REG_IDX_W-1:0] wb_rd,
    input logic                 wb_we
  );
    fwd_sel_e sel;
    sel = FWD_REGFILE;
    if (wb_we && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
    if (mem_we && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_sat_counter                                           |
// | Description : Saturating up-counter; holds at all-ones instead of wrapping.|
// | Ports       : clock   - core clock                                         |
// |               reset   - asynchronous active-low reset, clears the count    |
// |               inc_i   - add one this cycle (at most one step per cycle)    |
// |               count_o - current count                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hazard_control_unit                                          |
// | Description : Execute-stage hazard control for the 5-stage core: operand   |
// |               forwarding selects, load-use bubbles, taken-branch flushes,  |
// |               full-pipeline freeze while data memory is busy, saturating   |
// |               hazard statistics and a sticky memory-timeout flag.          |
// | Ports       : clock, reset (async active-low)                              |
// |               id*  - decode-stage source registers and their use flags     |
// |               ex*  - execute-stage register fields, load flag, taken flag  |
// |               mem*/wb* - later-stage destinations and write enables,       |
// |                          memory request / ready handshake                  |
// |               forwardA/B - operand select (00 RF, 01 MEM, 10 WB)           |
// |               *Stall/*Flush - pipeline register hold / bubble controls     |
// |               loadUseCount, flushCount, memWaitCount - statistics          |
// |               memTimeout - sticky, set after MAX_WAIT_CYCLES wait cycles   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT_CYCLES = 255,
  parameter int COUNTER_WIDTH   = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REG_IDX_W-1:0]     idRs1,
  input  logic [REG_IDX_W-1:0]     idRs2,
  input  logic                     idUsesRs1,
  input  logic                     idUsesRs2,
  input  logic [REG_IDX_W-1:0]     exRs1,
  input  logic [REG_IDX_W-1:0]     exRs2,
  input  logic [REG_IDX_W-1:0]     exRd,
  input  logic                     exMemoryReadEnable,
  input  logic                     exPcUpdate,
  input  logic [REG_IDX_W-1:0]     memRd,
  input  logic [REG_IDX_W-1:0]     wbRd,
  input  logic                     memRegisterWriteEnable,
  input  logic                     wbRegisterWriteEnable,
  input  logic                     memRequest,
  input  logic                     memReady,
  output logic [1:0]               forwardA,
  output logic [1:0]               forwardB,
  output logic                     pcStall,
  output logic                     fetchToDecodeStall,
  output logic                     fetchToDecodeFlush,
  output logic                     decodeToExecuteStall,
  output logic                     decodeToExecuteFlush,
  output logic                     executeToMemoryStall,
  output logic [COUNTER_WIDTH-1:0] loadUseCount,
  output logic [COUNTER_WIDTH-1:0] flushCount,
  output logic [COUNTER_WIDTH-1:0] memWaitCount,
  output logic                     memTimeout
);

  localparam int                WAIT_W   = (MAX_WAIT_CYCLES < 1) ? 1 : $clog2(MAX_WAIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT_CYCLES);

  hcu_state_e        state_q;
  hcu_state_e        state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              timeout_q;
  logic              timeout_d;

  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_load_use;
  logic              w_mem_busy;
  logic              w_freeze;
  logic              w_ctl_flush;
  logic              w_bubble;
  logic              w_inc_load_use;
  logic              w_inc_flush;
  logic              w_inc_mem_wait;

  // ---------------------------------------------------------------------------
  // Forwarding: purely combinational, independent of FSM state.
  // ---------------------------------------------------------------------------
  assign forwardA = fwd_select(exRs1, memRd, memRegisterWriteEnable, wbRd, wbRegisterWriteEnable);
  assign forwardB = fwd_select(exRs2, memRd, memRegisterWriteEnable, wbRd, wbRegisterWriteEnable);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_load_use = exMemoryReadEnable && (exRd != '0) &&
                      ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));
  assign w_mem_busy = memRequest && !memReady;

  // ---------------------------------------------------------------------------
  // Control FSM next-state and outputs.
  // The release condition of MEM_WAIT (ready or request dropped) is exactly
  // !w_mem_busy, so in both states the freeze tracks w_mem_busy and the
  // non-busy cycle applies the RUN branch/load-use priorities.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    timeout_d      = timeout_q;
    w_wait_inc     = wait_q;
    w_freeze       = 1'b0;
    w_ctl_flush    = 1'b0;
    w_bubble       = 1'b0;
    w_inc_load_use = 1'b0;
    w_inc_flush    = 1'b0;
    w_inc_mem_wait = 1'b0;

    if (state_q == MEM_WAIT) begin
      w_inc_mem_wait = 1'b1;
      // Saturate the wait counter so a very long wait cannot wrap it.
      w_wait_inc = (wait_q == WAIT_MAX) ? wait_q : (wait_q + WAIT_W'(1));
      if (w_wait_inc == WAIT_MAX) begin
        timeout_d = 1'b1;
      end
      wait_d = w_wait_inc;
    end

    if (w_mem_busy) begin
      w_freeze = 1'b1;
      state_d  = MEM_WAIT;
    end else begin
      state_d = RUN;
      wait_d  = '0;
      if (exPcUpdate) begin
        // The dependent decode instruction is on the wrong path; no bubble.
        w_ctl_flush = 1'b1;
        w_inc_flush = 1'b1;
      end else if (w_load_use) begin
        w_bubble       = 1'b1;
        w_inc_load_use = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are qualified with reset so asserting it clears every control
  // immediately, even while the memory handshake inputs still show busy.
  assign pcStall              = reset & (w_freeze | w_bubble);
  assign fetchToDecodeStall   = reset & (w_freeze | w_bubble);
  assign fetchToDecodeFlush   = reset & w_ctl_flush;
  assign decodeToExecuteStall = reset & w_freeze;
  assign decodeToExecuteFlush = reset & (w_ctl_flush | w_bubble);
  assign executeToMemoryStall = reset & w_freeze;
  assign memTimeout           = timeout_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  hazard_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_load_use_cnt (
    .clock   (clock),
    .reset   (reset),
    .inc_i   (w_inc_load_use),
    .count_o (loadUseCount)
  );

  hazard_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
    .clock   (clock),
    .reset   (reset),
    .inc_i   (w_inc_flush),
    .count_o (flushCount)
  );

  hazard_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_mem_wait_cnt (
    .clock   (clock),
    .reset   (reset),
    .inc_i   (w_inc_mem_wait),
    .count_o (memWaitCount)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hazard_control_unit                                       |
// | Description : Scoreboard bench for hazard_control_unit. A driver applies   |
// |               directed and random stimulus and pushes the expected         |
// |               response from a behavioural model; a negedge monitor pops    |
// |               and compares.                                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hazard_control_unit;

  localparam int MAXW = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
  logic          idUsesRs1, idUsesRs2, exMemoryReadEnable, exPcUpdate;
  logic          memRegisterWriteEnable, wbRegisterWriteEnable, memRequest, memReady;
  logic [1:0]    forwardA, forwardB;
  logic          pcStall, fetchToDecodeStall, fetchToDecodeFlush;
  logic          decodeToExecuteStall, decodeToExecuteFlush, executeToMemoryStall;
  logic [CW-1:0] loadUseCount, flushCount, memWaitCount;
  logic          memTimeout;

  hazard_control_unit #(.MAX_WAIT_CYCLES(MAXW), .COUNTER_WIDTH(CW)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .idRs1                  (idRs1),
    .idRs2                  (idRs2),
    .idUsesRs1              (idUsesRs1),
    .idUsesRs2              (idUsesRs2),
    .exRs1                  (exRs1),
    .exRs2                  (exRs2),
    .exRd                   (exRd),
    .exMemoryReadEnable     (exMemoryReadEnable),
    .exPcUpdate             (exPcUpdate),
    .memRd                  (memRd),
    .wbRd                   (wbRd),
    .memRegisterWriteEnable (memRegisterWriteEnable),
    .wbRegisterWriteEnable  (wbRegisterWriteEnable),
    .memRequest             (memRequest),
    .memReady               (memReady),
    .forwardA               (forwardA),
    .forwardB               (forwardB),
    .pcStall                (pcStall),
    .fetchToDecodeStall     (fetchToDecodeStall),
    .fetchToDecodeFlush     (fetchToDecodeFlush),
    .decodeToExecuteStall   (decodeToExecuteStall),
    .decodeToExecuteFlush   (decodeToExecuteFlush),
    .executeToMemoryStall   (executeToMemoryStall),
    .loadUseCount           (loadUseCount),
    .flushCount             (flushCount),
    .memWaitCount           (memWaitCount),
    .memTimeout             (memTimeout)
  );

  always #5 clock = ~clock;

  // Control vector order: pcStall, fdStall, fdFlush, deStall, deFlush, emStall
  localparam logic [5:0] CTL_IDLE   = 6'b000000;
  localparam logic [5:0] CTL_FREEZE = 6'b110101;
  localparam logic [5:0] CTL_BRANCH = 6'b001010;
  localparam logic [5:0] CTL_BUBBLE = 6'b110010;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [5:0] ctl;
    int         lu;
    int         fl;
    int         mw;
    logic       mto;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Reference model state: was memory busy last cycle, length of the current
  // wait run, statistics and the sticky timeout.
  bit m_waiting;
  int m_run, m_lu, m_fl, m_mw;
  bit m_to;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (memRegisterWriteEnable && memRd != 0 && memRd == rs) return 2'b01;
    if (wbRegisterWriteEnable && wbRd != 0 && wbRd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {pcStall, fetchToDecodeStall, fetchToDecodeFlush,
            decodeToExecuteStall, decodeToExecuteFlush, executeToMemoryStall};
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_run = 0; m_lu = 0; m_fl = 0; m_mw = 0; m_to = 0;
    sb.delete();
  endtask

  task automatic set_idle();
    idRs1 = 0; idRs2 = 0; exRs1 = 0; exRs2 = 0; exRd = 0; memRd = 0; wbRd = 0;
    idUsesRs1 = 0; idUsesRs2 = 0; exMemoryReadEnable = 0; exPcUpdate = 0;
    memRegisterWriteEnable = 0; wbRegisterWriteEnable = 0; memRequest = 0; memReady = 0;
  endtask

  // Predict this cycle's response from the current inputs, queue it, advance
  // the model to the next cycle and let one clock edge pass.
  task automatic drive_cycle();
    exp_t e;
    bit   busy, lu;
    busy  = memRequest && !memReady;
    lu    = exMemoryReadEnable && exRd != 0 &&
            ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
    e.fa  = ref_fwd(exRs1);
    e.fb  = ref_fwd(exRs2);
    e.lu  = m_lu; e.fl = m_fl; e.mw = m_mw; e.mto = m_to;
    if (busy)            e.ctl = CTL_FREEZE;
    else if (exPcUpdate) begin e.ctl = CTL_BRANCH; m_fl = sat_inc(m_fl); end
    else if (lu)         begin e.ctl = CTL_BUBBLE; m_lu = sat_inc(m_lu); end
    else                 e.ctl = CTL_IDLE;
    if (m_waiting) begin
      m_mw = sat_inc(m_mw);
      m_run++;
      if (m_run >= MAXW) m_to = 1;
    end
    if (!busy) m_run = 0;
    m_waiting = busy;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && sb.size() > 0) begin
      e = sb.pop_front();
      chk("fwdA",     32'(forwardA),     32'(e.fa));
      chk("fwdB",     32'(forwardB),     32'(e.fb));
      chk("ctl",      32'(ctl_now()),    32'(e.ctl));
      chk("luCount",  32'(loadUseCount), 32'(e.lu));
      chk("flCount",  32'(flushCount),   32'(e.fl));
      chk("mwCount",  32'(memWaitCount), 32'(e.mw));
      chk("timeout",  32'(memTimeout),   32'(e.mto));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst_ctl",   32'(ctl_now()), 32'(CTL_IDLE));
    chk("rst_cnts",  32'({loadUseCount, flushCount, memWaitCount, memTimeout}), 32'(0));

    // add x3,x1,x2 with x1 produced by both MEM and WB: MEM wins
    exRs1 = 1; exRs2 = 2; memRd = 1; wbRd = 1;
    memRegisterWriteEnable = 1; wbRegisterWriteEnable = 1;
    #1 chk("add_fwdA", 32'(forwardA), 32'(2'b01));
    drive_cycle();
    set_idle();

    // lw x5 in execute, decode reads x5 as rs2
    exMemoryReadEnable = 1; exRd = 5; idUsesRs2 = 1; idRs2 = 5;
    #1 chk("lu_ctl", 32'(ctl_now()), 32'(CTL_BUBBLE));
    drive_cycle();
    chk("lu_count1", 32'(loadUseCount), 32'(1));
    exRd = 0; idRs2 = 0;
    #1 chk("lu_x0_ctl", 32'(ctl_now()), 32'(CTL_IDLE));
    drive_cycle();
    set_idle();

    // taken branch masks a load-use
    exMemoryReadEnable = 1; exRd = 7; idUsesRs1 = 1; idRs1 = 7; exPcUpdate = 1;
    #1 chk("br_ctl", 32'(ctl_now()), 32'(CTL_BRANCH));
    drive_cycle();
    chk("br_flCount", 32'(flushCount), 32'(1));
    chk("br_luCount", 32'(loadUseCount), 32'(1));
    set_idle();

    // three not-ready cycles with a branch held; flush on release
    memRequest = 1; memReady = 0; exPcUpdate = 1;
    repeat (3) drive_cycle();
    memReady = 1;
    #1 chk("rel_ctl", 32'(ctl_now()), 32'(CTL_BRANCH));
    drive_cycle();
    set_idle();
    #1 chk("mw_count3", 32'(memWaitCount), 32'(3));
    drive_cycle();

    // six not-ready cycles: timeout after the fourth wait cycle, sticky
    memRequest = 1; memReady = 0;
    repeat (4) drive_cycle();
    chk("to_before", 32'(memTimeout), 32'(0));
    drive_cycle();
    chk("to_after", 32'(memTimeout), 32'(1));
    drive_cycle();
    memReady = 1;
    drive_cycle();
    set_idle();
    repeat (2) drive_cycle();
    chk("to_sticky", 32'(memTimeout), 32'(1));

    // asynchronous reset in the middle of MEM_WAIT with memory still busy
    memRequest = 1; memReady = 0;
    drive_cycle();
    #2 reset = 1'b0;
    #1;
    chk("arst_ctl",  32'(ctl_now()), 32'(CTL_IDLE));
    chk("arst_cnts", 32'({loadUseCount, flushCount, memWaitCount, memTimeout}), 32'(0));
    model_reset();
    set_idle();
    @(posedge clock);
    #1 reset = 1'b1;
    #1 chk("arst_run", 32'(ctl_now()), 32'(CTL_IDLE));
    drive_cycle();

    // nine load-use events saturate the 3-bit counter
    exMemoryReadEnable = 1; exRd = 9; idUsesRs1 = 1; idRs1 = 9;
    repeat (9) drive_cycle();
    set_idle();
    #1 chk("lu_sat", 32'(loadUseCount), 32'(CMAX));
    drive_cycle();

    // randomized traffic; small register range so matches are frequent
    for (int i = 0; i < 400; i++) begin
      idRs1 = 5'($urandom_range(0, 3));
      idRs2 = 5'($urandom_range(0, 3));
      exRs1 = 5'($urandom_range(0, 3));
      exRs2 = 5'($urandom_range(0, 3));
      exRd  = 5'($urandom_range(0, 3));
      memRd = 5'($urandom_range(0, 3));
      wbRd  = 5'($urandom_range(0, 3));
      idUsesRs1              = ($urandom_range(0, 3) != 0);
      idUsesRs2              = ($urandom_range(0, 1) != 0);
      exMemoryReadEnable     = ($urandom_range(0, 2) == 0);
      exPcUpdate             = ($urandom_range(0, 4) == 0);
      memRegisterWriteEnable = ($urandom_range(0, 1) != 0);
      wbRegisterWriteEnable  = ($urandom_range(0, 1) != 0);
      memRequest             = ($urandom_range(0, 2) == 0);
      memReady               = (i % 100 < 50) ? ($urandom_range(0, 5) == 0)
                                              : ($urandom_range(0, 1) != 0);
      drive_cycle();
    end
    set_idle();
    drive_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
